// File: rtl/ahb_slave_wait_ram_if.sv
// AHB-Lite bus bundle between a master-side port and the wait-state RAM.
// The master modport drives requests; the slave modport returns responses.
interface ahb_slave_wait_ram_if;
    logic        HSEL_SLAVE;
    logic [31:0] HADDR_SLAVE;
    logic [1:0]  HTRANS_SLAVE;
    logic        HWRITE_SLAVE;
    logic [2:0]  HSIZE_SLAVE;
    logic [2:0]  HBURST_SLAVE;
    logic [3:0]  HPROT_SLAVE;
    logic        HMASTLOCK_SLAVE;
    logic [31:0] HWDATA_SLAVE;
    logic        HREADY_SLAVE;
    logic [31:0] HRDATA_SLAVE;
    logic        HREADYOUT_SLAVE;
    logic [1:0]  HRESP_SLAVE;

    modport master (
        output HSEL_SLAVE, HADDR_SLAVE, HTRANS_SLAVE, HWRITE_SLAVE,
        output HSIZE_SLAVE, HBURST_SLAVE, HPROT_SLAVE, HMASTLOCK_SLAVE,
        output HWDATA_SLAVE, HREADY_SLAVE,
        input  HRDATA_SLAVE, HREADYOUT_SLAVE, HRESP_SLAVE
    );

    modport slave (
        input  HSEL_SLAVE, HADDR_SLAVE, HTRANS_SLAVE, HWRITE_SLAVE,
        input  HSIZE_SLAVE, HBURST_SLAVE, HPROT_SLAVE, HMASTLOCK_SLAVE,
        input  HWDATA_SLAVE, HREADY_SLAVE,
        output HRDATA_SLAVE, HREADYOUT_SLAVE, HRESP_SLAVE
    );
endinterface

// File: rtl/ahb_slave_wait_ram.sv
// AHB-Lite RAM responder with programmable wait states and two-cycle
// ERROR responses for misaligned or oversized transfers.
module ahb_slave_wait_ram #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    ahb_slave_wait_ram_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    hreadyout_q;
    logic [1:0]              hresp_q;
    logic                    final_q;
    logic                    write_q;
    logic [2:0]              size_q;
    logic [1:0]              lane_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             ram_q [DEPTH];

    logic                    accept;
    logic                    illegal;
    logic                    commit;
    logic [3:0]              be;
    logic                    unused_inputs;

    assign accept = bus.HSEL_SLAVE & bus.HREADY_SLAVE & bus.HTRANS_SLAVE[1];

    // final_q is only set while HREADYOUT is high, so it marks the
    // cycle whose closing edge commits write data
    assign commit = final_q & write_q;

    assign unused_inputs = ^{bus.HBURST_SLAVE, bus.HPROT_SLAVE,
                             bus.HMASTLOCK_SLAVE, bus.HTRANS_SLAVE[0],
                             bus.HADDR_SLAVE[31:ADDR_WIDTH+2]};

    // Classify the address phase currently on the bus as legal or not
    always_comb begin
        illegal = 1'b0;
        if (bus.HSIZE_SLAVE > 3'd2) begin
            illegal = 1'b1;
        end else if (bus.HSIZE_SLAVE == 3'd1 && bus.HADDR_SLAVE[0]) begin
            illegal = 1'b1;
        end else if (bus.HSIZE_SLAVE == 3'd2 &&
                     bus.HADDR_SLAVE[1:0] != 2'b00) begin
            illegal = 1'b1;
        end
    end

    // Little-endian byte enables for the registered transfer
    always_comb begin
        be = 4'b0000;
        case (size_q)
            3'd0:    be[lane_q] = 1'b1;
            3'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
            3'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Transfer FSM with registered HREADYOUT/HRESP and address capture
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 2'b00;
            final_q     <= 1'b0;
            write_q     <= 1'b0;
            size_q      <= 3'd0;
            lane_q      <= 2'b00;
            idx_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_ERR2: begin
                    if (accept) begin
                        write_q <= bus.HWRITE_SLAVE;
                        size_q  <= bus.HSIZE_SLAVE;
                        lane_q  <= bus.HADDR_SLAVE[1:0];
                        idx_q   <= bus.HADDR_SLAVE[ADDR_WIDTH+1:2];
                        if (illegal) begin
                            state_q     <= S_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 2'b01;
                            final_q     <= 1'b0;
                        end else if (WAIT_STATES > 0) begin
                            state_q     <= S_WAIT;
                            cnt_q       <= 4'(WAIT_STATES - 1);
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 2'b00;
                            final_q     <= 1'b0;
                        end else begin
                            state_q     <= S_IDLE;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= 2'b00;
                            final_q     <= 1'b1;
                        end
                    end else begin
                        state_q     <= S_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 2'b00;
                        final_q     <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= S_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 2'b00;
                        final_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ERR1: begin
                    state_q     <= S_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 2'b01;
                end
                default: begin
                    state_q     <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 2'b00;
                    final_q     <= 1'b0;
                end
            endcase
        end
    end

    // RAM array: cleared on reset, byte-lane writes at end of final cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ram_q[i] <= '0;
            end
        end else if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    ram_q[idx_q][8*b +: 8] <= bus.HWDATA_SLAVE[8*b +: 8];
                end
            end
        end
    end

    assign bus.HREADYOUT_SLAVE = hreadyout_q;
    assign bus.HRESP_SLAVE     = hresp_q;
    assign bus.HRDATA_SLAVE    = (final_q && !write_q) ? ram_q[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_wait_ram.sv
// Bench for ahb_slave_wait_ram: one instance with one wait state and one
// with none; read expectations travel through a scoreboard queue.
module tb_ahb_slave_wait_ram;
    logic        clock;
    logic        resetn;
    logic        sel;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready_lo;
    logic        rdy_o;
    logic [1:0]  resp_o;
    logic [31:0] rdata_o;

    int n_cmp;
    int n_bad;
    logic [31:0] exp_q [$];

    ahb_slave_wait_ram_if if0 ();
    ahb_slave_wait_ram_if if1 ();

    ahb_slave_wait_ram #(.ADDR_WIDTH(8), .WAIT_STATES(1)) u_ws1 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (if0)
    );

    ahb_slave_wait_ram #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (if1)
    );

    assign if0.HSEL_SLAVE      = hsel & ~sel;
    assign if0.HADDR_SLAVE     = haddr;
    assign if0.HTRANS_SLAVE    = htrans;
    assign if0.HWRITE_SLAVE    = hwrite;
    assign if0.HSIZE_SLAVE     = hsize;
    assign if0.HBURST_SLAVE    = 3'd0;
    assign if0.HPROT_SLAVE     = 4'h3;
    assign if0.HMASTLOCK_SLAVE = 1'b0;
    assign if0.HWDATA_SLAVE    = hwdata;
    assign if0.HREADY_SLAVE    = if0.HREADYOUT_SLAVE & ~(hready_lo & ~sel);

    assign if1.HSEL_SLAVE      = hsel & sel;
    assign if1.HADDR_SLAVE     = haddr;
    assign if1.HTRANS_SLAVE    = htrans;
    assign if1.HWRITE_SLAVE    = hwrite;
    assign if1.HSIZE_SLAVE     = hsize;
    assign if1.HBURST_SLAVE    = 3'd1;
    assign if1.HPROT_SLAVE     = 4'h3;
    assign if1.HMASTLOCK_SLAVE = 1'b0;
    assign if1.HWDATA_SLAVE    = hwdata;
    assign if1.HREADY_SLAVE    = if1.HREADYOUT_SLAVE & ~(hready_lo & sel);

    assign rdy_o   = sel ? if1.HREADYOUT_SLAVE : if0.HREADYOUT_SLAVE;
    assign resp_o  = sel ? if1.HRESP_SLAVE     : if0.HRESP_SLAVE;
    assign rdata_o = sel ? if1.HRDATA_SLAVE    : if0.HRDATA_SLAVE;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One non-pipelined transfer; reports wait count and responses
    task automatic xfer(input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output int nw, output logic [1:0] r1,
                        output logic [1:0] rf, output logic [31:0] rd,
                        output logic tmo);
        haddr = a; hwrite = w; hsize = sz; htrans = 2'b10; hsel = 1'b1;
        @(posedge clock); #1;
        htrans = 2'b00; hsel = 1'b0; hwdata = wd;
        nw = 0; tmo = 1'b1; r1 = 2'b00; rf = 2'b00; rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i == 0) r1 = resp_o;
            if (rdy_o) begin
                rf = resp_o; rd = rdata_o; tmo = 1'b0;
                break;
            end
            nw++;
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp++; if (if0.HREADYOUT_SLAVE !== 1'b1) begin n_bad++;
            $display("FAIL rst_rdy0: got %b want 1", if0.HREADYOUT_SLAVE); end
        n_cmp++; if (if0.HRESP_SLAVE !== 2'b00) begin n_bad++;
            $display("FAIL rst_resp0: got %b want 00", if0.HRESP_SLAVE); end
        n_cmp++; if (if0.HRDATA_SLAVE !== 32'h0) begin n_bad++;
            $display("FAIL rst_rdata0: got %h want 0", if0.HRDATA_SLAVE); end
        n_cmp++; if (if1.HREADYOUT_SLAVE !== 1'b1) begin n_bad++;
            $display("FAIL rst_rdy1: got %b want 1", if1.HREADYOUT_SLAVE); end
        n_cmp++; if (if1.HRESP_SLAVE !== 2'b00) begin n_bad++;
            $display("FAIL rst_resp1: got %b want 00", if1.HRESP_SLAVE); end
        resetn = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_word_rw();
        int nw; logic [1:0] r1, rf; logic [31:0] rd, ex; logic tmo;
        sel = 1'b0;
        xfer(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, nw, r1, rf, rd, tmo);
        n_cmp++; if (tmo !== 1'b0 || nw !== 1) begin n_bad++;
            $display("FAIL wr_waits: got %0d tmo %b want 1", nw, tmo); end
        n_cmp++; if (rf !== 2'b00) begin n_bad++;
            $display("FAIL wr_resp: got %b want 00", rf); end
        exp_q.push_back(32'hDEADBEEF);
        xfer(32'h10, 1'b0, 3'd2, 32'h0, nw, r1, rf, rd, tmo);
        ex = exp_q.pop_front();
        n_cmp++; if (tmo !== 1'b0 || nw !== 1) begin n_bad++;
            $display("FAIL rd_waits: got %0d tmo %b want 1", nw, tmo); end
        n_cmp++; if (rd !== ex) begin n_bad++;
            $display("FAIL rd_data: got %h want %h", rd, ex); end
        n_cmp++; if (rf !== 2'b00) begin n_bad++;
            $display("FAIL rd_resp: got %b want 00", rf); end
    endtask

    task automatic test_byte_half();
        int nw; logic [1:0] r1, rf; logic [31:0] rd, ex; logic tmo;
        sel = 1'b0;
        xfer(32'h10, 1'b1, 3'd2, 32'h11223344, nw, r1, rf, rd, tmo);
        xfer(32'h11, 1'b1, 3'd0, 32'hAAAAAAAA, nw, r1, rf, rd, tmo);
        exp_q.push_back(32'h1122AA44);
        xfer(32'h10, 1'b0, 3'd2, 32'h0, nw, r1, rf, rd, tmo);
        ex = exp_q.pop_front();
        n_cmp++; if (tmo !== 1'b0 || rd !== ex) begin n_bad++;
            $display("FAIL byte_wr: got %h want %h", rd, ex); end
        xfer(32'h12, 1'b1, 3'd1, 32'h55665566, nw, r1, rf, rd, tmo);
        exp_q.push_back(32'h5566AA44);
        xfer(32'h10, 1'b0, 3'd2, 32'h0, nw, r1, rf, rd, tmo);
        ex = exp_q.pop_front();
        n_cmp++; if (tmo !== 1'b0 || rd !== ex) begin n_bad++;
            $display("FAIL half_wr: got %h want %h", rd, ex); end
    endtask

    task automatic test_error();
        int nw; logic [1:0] r1, rf; logic [31:0] rd, ex; logic tmo;
        logic [31:0] ea [3];
        logic [2:0]  es [3];
        logic        ew [3];
        sel = 1'b0;
        xfer(32'h20, 1'b1, 3'd2, 32'h01020304, nw, r1, rf, rd, tmo);
        ea[0] = 32'h02; es[0] = 3'd2; ew[0] = 1'b0;
        ea[1] = 32'h00; es[1] = 3'd3; ew[1] = 1'b0;
        ea[2] = 32'h20; es[2] = 3'd3; ew[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            xfer(ea[k], ew[k], es[k], 32'hCAFEF00D, nw, r1, rf, rd, tmo);
            n_cmp++; if (tmo !== 1'b0 || nw !== 1) begin n_bad++;
                $display("FAIL err%0d_waits: got %0d want 1", k, nw); end
            n_cmp++; if (r1 !== 2'b01) begin n_bad++;
                $display("FAIL err%0d_resp1: got %b want 01", k, r1); end
            n_cmp++; if (rf !== 2'b01) begin n_bad++;
                $display("FAIL err%0d_resp2: got %b want 01", k, rf); end
            n_cmp++; if (rd !== 32'h0) begin n_bad++;
                $display("FAIL err%0d_rdata: got %h want 0", k, rd); end
            @(negedge clock);
            n_cmp++; if (rdy_o !== 1'b1 || resp_o !== 2'b00) begin
                n_bad++;
                $display("FAIL err%0d_idle: got %b/%b want 1/00",
                         k, rdy_o, resp_o); end
            @(posedge clock); #1;
        end
        exp_q.push_back(32'h01020304);
        xfer(32'h20, 1'b0, 3'd2, 32'h0, nw, r1, rf, rd, tmo);
        ex = exp_q.pop_front();
        n_cmp++; if (tmo !== 1'b0 || rd !== ex) begin n_bad++;
            $display("FAIL err_nowrite: got %h want %h", rd, ex); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ex;
        sel = 1'b1;
        haddr = 32'h0; hwrite = 1'b1; hsize = 3'd2;
        htrans = 2'b10; hsel = 1'b1;
        @(posedge clock); #1;
        hwrite = 1'b0; hwdata = 32'h1;
        exp_q.push_back(32'h00000001);
        @(negedge clock);
        n_cmp++; if (rdy_o !== 1'b1) begin n_bad++;
            $display("FAIL b2b_wr_rdy: got %b want 1", rdy_o); end
        n_cmp++; if (rdata_o !== 32'h0) begin n_bad++;
            $display("FAIL b2b_wr_rdata: got %h want 0", rdata_o); end
        @(posedge clock); #1;
        htrans = 2'b00; hsel = 1'b0;
        @(negedge clock);
        ex = exp_q.pop_front();
        n_cmp++; if (rdy_o !== 1'b1 || resp_o !== 2'b00) begin n_bad++;
            $display("FAIL b2b_rd_rdy: got %b/%b want 1/00", rdy_o, resp_o);
        end
        n_cmp++; if (rdata_o !== ex) begin n_bad++;
            $display("FAIL b2b_rd_data: got %h want %h", rdata_o, ex); end
        @(posedge clock); #1;
        sel = 1'b0;
    endtask

    task automatic test_idle_busy();
        int nw; logic [1:0] r1, rf; logic [31:0] rd, ex; logic tmo;
        logic [1:0] tt [2];
        tt[0] = 2'b00; tt[1] = 2'b01;
        sel = 1'b0;
        for (int k = 0; k < 2; k++) begin
            haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
            htrans = tt[k]; hsel = 1'b1;
            @(posedge clock); #1;
            htrans = 2'b00; hsel = 1'b0; hwdata = 32'hFFFFFFFF;
            @(negedge clock);
            n_cmp++; if (rdy_o !== 1'b1 || resp_o !== 2'b00 ||
                         rdata_o !== 32'h0) begin n_bad++;
                $display("FAIL idle%0d: got %b/%b/%h want 1/00/0",
                         k, rdy_o, resp_o, rdata_o); end
            @(posedge clock); #1;
        end
        haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
        htrans = 2'b10; hsel = 1'b1; hready_lo = 1'b1;
        @(posedge clock); #1;
        htrans = 2'b00; hsel = 1'b0; hready_lo = 1'b0;
        hwdata = 32'hFFFFFFFF;
        @(negedge clock);
        n_cmp++; if (rdy_o !== 1'b1 || rdata_o !== 32'h0) begin n_bad++;
            $display("FAIL hrdy_lo: got %b/%h want 1/0", rdy_o, rdata_o); end
        @(posedge clock); #1;
        exp_q.push_back(32'h5566AA44);
        xfer(32'h10, 1'b0, 3'd2, 32'h0, nw, r1, rf, rd, tmo);
        ex = exp_q.pop_front();
        n_cmp++; if (tmo !== 1'b0 || rd !== ex) begin n_bad++;
            $display("FAIL idle_ram: got %h want %h", rd, ex); end
    endtask

    task automatic test_reset_mid();
        int nw; logic [1:0] r1, rf; logic [31:0] rd, ex; logic tmo;
        sel = 1'b0;
        haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
        htrans = 2'b10; hsel = 1'b1;
        @(posedge clock); #1;
        htrans = 2'b00; hsel = 1'b0; hwdata = 32'h12345678;
        @(negedge clock);
        n_cmp++; if (rdy_o !== 1'b0) begin n_bad++;
            $display("FAIL mid_wait: got %b want 0", rdy_o); end
        #1 resetn = 1'b0;
        #1;
        n_cmp++; if (rdy_o !== 1'b1 || resp_o !== 2'b00) begin n_bad++;
            $display("FAIL mid_rst: got %b/%b want 1/00", rdy_o, resp_o); end
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        exp_q.push_back(32'h0);
        xfer(32'h40, 1'b0, 3'd2, 32'h0, nw, r1, rf, rd, tmo);
        ex = exp_q.pop_front();
        n_cmp++; if (tmo !== 1'b0 || rd !== ex) begin n_bad++;
            $display("FAIL mid_ram: got %h want %h", rd, ex); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        sel = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00;
        hwrite = 1'b0; hsize = 3'd2; hwdata = '0; hready_lo = 1'b0;
        resetn = 1'b0;
        test_reset();
        test_word_rw();
        test_byte_half();
        test_error();
        test_back_to_back();
        test_idle_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_slave_wait_ram.md
Name: ahb_slave_wait_ram

Overview:
- AHB-Lite responder (slave) that terminates transfers driven by the bridge's master-side port.
- Provides a word-organised RAM window with byte/halfword/word writes, a programmable number of wait states, and two-cycle ERROR responses for illegal transfers.
- Used as a scratch/line buffer and as the bus-compliance target for the bridge path.

Parameters:
- ADDR_WIDTH, 8, word-index width; RAM depth = 2**ADDR_WIDTH 32-bit words (256 words default).
- WAIT_STATES, 1, HREADYOUT low cycles inserted per valid NONSEQ/SEQ transfer (0..15).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- HSEL_SLAVE  in  1  slave select.
- HADDR_SLAVE  in  32  byte address; bits [ADDR_WIDTH+1:2] index the RAM, upper bits ignored.
- HTRANS_SLAVE  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE_SLAVE  in  1  1=write.
- HSIZE_SLAVE  in  3  transfer size: 0=byte, 1=half, 2=word.
- HBURST_SLAVE  in  3  accepted, ignored.
- HPROT_SLAVE  in  4  accepted, ignored.
- HMASTLOCK_SLAVE  in  1  accepted, ignored.
- HWDATA_SLAVE  in  32  write data, data phase.
- HREADY_SLAVE  in  1  bus-level HREADY (previous transfer complete).
- HRDATA_SLAVE  out  32  read data.
- HREADYOUT_SLAVE  out  1  transfer-done indication.
- HRESP_SLAVE  out  2  00=OKAY, 01=ERROR.

Behaviour:
- Reset (async, resetn low): HREADYOUT_SLAVE=1, HRESP_SLAVE=00, HRDATA_SLAVE=0, FSM=IDLE, wait counter=0, all RAM words cleared to 0.
- Address-phase accept: HSEL_SLAVE & HREADY_SLAVE & HTRANS_SLAVE[1] on a rising edge. Registers address, size, write and index.
- HTRANS IDLE/BUSY, HSEL low, or HREADY_SLAVE low: not accepted. The next data phase is a zero-wait OKAY with no RAM access.
- Illegal transfer: HSIZE_SLAVE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE, legal accept: go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1, HREADYOUT=0); otherwise the next cycle is the final data cycle.
  - IDLE, illegal accept: go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=00. Counter decrements. At 0, the next cycle is the final cycle (HREADYOUT=1, OKAY) and the FSM returns to IDLE.
  - ERR1: HREADYOUT=0, HRESP=01, then ERR2.
  - ERR2: HREADYOUT=1, HRESP=01, then IDLE. No RAM access for an errored transfer.
- Final data cycle:
  - Read: HRDATA_SLAVE = RAM[index]. In all other cycles HRDATA_SLAVE=0.
  - Write: HWDATA_SLAVE is sampled at the end of the final cycle (HREADYOUT=1). Byte lanes are little-endian.
    - Byte: lane HADDR[1:0].
    - Half: lanes {HADDR[1],0} and {HADDR[1],1}.
    - Word: all four lanes. Unselected lanes are unchanged.
  - Reads return the full word regardless of HSIZE; the master extracts lanes.
- Pipelining: a new address phase presented during the final data cycle (HREADY_SLAVE=1) is accepted in that same cycle. Back-to-back transfers then see exactly WAIT_STATES low cycles each.
- Read-after-write to the same index on consecutive transfers returns the newly written data. The write commits before the read's final cycle for any WAIT_STATES, including 0.
- Accepts arriving in WAIT/ERR1 cannot occur because HREADY_SLAVE=0 there; the design ignores them.
- resetn asserted mid-transfer: abort immediately, outputs take reset values, in-flight write discarded.

Test Plan:
- Reset, WAIT_STATES=1; word write 0xDEADBEEF to 0x10, then word read of 0x10 -> write data phase shows HREADYOUT 0 then 1; read returns 0xDEADBEEF with 1 wait cycle, HRESP=00.
- Byte write 0xAA to 0x11 over word 0x11223344 at 0x10 -> read returns 0x1122AA44. Halfword write 0x5566 to 0x12 -> read returns 0x5566AA44.
- Unaligned word read at 0x02 -> ERR1 (HREADYOUT=0, HRESP=01), ERR2 (HREADYOUT=1, HRESP=01), then IDLE. HSIZE=3 behaves the same. A write to 0x20 with HSIZE=3 leaves 0x20 unchanged.
- WAIT_STATES=0; back-to-back NONSEQ write 0x1 to 0x0 then read 0x0 -> HREADYOUT stays 1 throughout and the read returns 0x00000001.
- HTRANS=IDLE/BUSY with HSEL=1, and HSEL=1 with HREADY_SLAVE=0 -> zero-wait OKAY, RAM unchanged, HRDATA=0.
- resetn low during WAIT of a write to 0x40 with data 0x12345678 -> HREADYOUT=1, HRESP=00 immediately; a subsequent read of 0x40 returns 0.
